fifo_wr_guard: RTL and testbench

//  Write-side front end of the async stream FIFO, in the wr_clk domain. Takes the AXI-style input stream
//  and drives the FIFO write port only while the FIFO reset/enable sequencer has released en_wr_en.

---
 rtl/fifo_wr_guard_pkg.sv | 23 ++
 rtl/fifo_wr_guard_if.sv | 27 ++
 rtl/fifo_wr_guard_skid.sv | 60 ++++++
 rtl/fifo_wr_guard.sv | 99 +++++++++
 tb/tb_fifo_wr_guard.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_guard_pkg.sv
// Shared types and helpers for the write-side guard of the async stream FIFO.
package fifo_wr_guard_pkg;

   typedef enum logic [1:0] {
      WG_BLOCK = 2'd0,
      WG_RUN   = 2'd1,
      WG_DROP  = 2'd2
   } wr_guard_state_e;

   localparam int SKID_DEPTH = 2;

   // Saturating add for statistics counters up to 32 bits wide; result clamps at 2^width-1.
   function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                           input logic [1:0]  inc,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [32:0] max_val;
      max_val = (33'd1 << width) - 33'd1;
      sum     = {1'b0, cnt} + {31'd0, inc};
      return (sum > max_val) ? max_val[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/fifo_wr_guard_if.sv
// Stream input, FIFO write port and statistics of the write guard, bundled as one interface.
interface fifo_wr_guard_if #(
   parameter int DSIZE = 16,
   parameter int CNT_W = 16
);
   logic             en_wr_en;
   logic [DSIZE-1:0] s_data;
   logic             s_valid;
   logic             s_last;
   logic             s_ready;
   logic             fifo_full;
   logic             fifo_wr_en;
   logic [DSIZE:0]   fifo_din;
   logic [CNT_W-1:0] pkt_cnt;
   logic [CNT_W-1:0] drop_cnt;

   // master: upstream source plus FIFO/sequencer side; slave: the guard itself
   modport master (
      output en_wr_en, s_data, s_valid, s_last, fifo_full,
      input  s_ready, fifo_wr_en, fifo_din, pkt_cnt, drop_cnt
   );

   modport slave (
      input  en_wr_en, s_data, s_valid, s_last, fifo_full,
      output s_ready, fifo_wr_en, fifo_din, pkt_cnt, drop_cnt
   );
endinterface

// File: rtl/fifo_wr_guard_skid.sv
// Two-entry register skid buffer; head entry is always slot 0, flush empties it in one cycle.
module wr_skid_buf
   import fifo_wr_guard_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         flush,
   output logic [1:0]   occupancy
);

   logic [W-1:0] slot_q [SKID_DEPTH];
   logic [W-1:0] slot_d [SKID_DEPTH];
   logic [1:0]   occ_q, occ_d;
   logic         push, pop;

   assign in_ready  = (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = slot_q[0];
   assign occupancy = occ_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      slot_d = slot_q;
      occ_d  = occ_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         if (pop) begin
            slot_d[0] = slot_q[1];
            occ_d     = occ_q - 2'd1;
         end
         // A push lands behind whatever survives the pop, so order is preserved.
         if (push) begin
            if (occ_d == 2'd0) slot_d[0] = in_data;
            else               slot_d[1] = in_data;
            occ_d = occ_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= 2'd0;
         for (int i = 0; i < SKID_DEPTH; i++) slot_q[i] <= '0;
      end else begin
         occ_q  <= occ_d;
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/fifo_wr_guard.sv
// Write-side front end of the async stream FIFO: gates writes on the sequencer enable,
// discards the tail of packets cut by a FIFO reset and keeps packet/drop statistics.
module fifo_wr_guard
   import fifo_wr_guard_pkg::*;
#(
   parameter int DSIZE = 16,
   parameter int CNT_W = 16
) (
   input  logic            wr_clk,
   input  logic            wr_rst_Q,
   fifo_wr_guard_if.slave  bus
);

   wr_guard_state_e  state_q, state_d;
   logic             s_ready_q, s_ready_d;
   logic             in_pkt_q, in_pkt_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [1:0]       drop_inc;

   logic             accept, push, push_ok, flush, wr_fire;
   logic             buf_in_ready, buf_out_valid, buf_out_ready;
   logic [DSIZE:0]   buf_out_data;
   logic [1:0]       occ, occ_next;

   assign accept        = bus.s_valid && s_ready_q;
   assign push          = accept && (state_q == WG_RUN) && bus.en_wr_en;
   assign push_ok       = push && buf_in_ready;
   assign flush         = (state_q == WG_RUN) && !bus.en_wr_en;
   assign buf_out_ready = (state_q == WG_RUN) && bus.en_wr_en && !bus.fifo_full;
   assign wr_fire       = buf_out_valid && buf_out_ready;
   assign occ_next      = flush ? 2'd0 : occ + {1'b0, push_ok} - {1'b0, wr_fire};

   wr_skid_buf #(.W(DSIZE + 1)) u_skid (
      .clk       (wr_clk),
      .rst       (wr_rst_Q),
      .in_data   ({bus.s_last, bus.s_data}),
      .in_valid  (push),
      .in_ready  (buf_in_ready),
      .out_data  (buf_out_data),
      .out_valid (buf_out_valid),
      .out_ready (buf_out_ready),
      .flush     (flush),
      .occupancy (occ)
   );

   always_comb begin
      state_d  = state_q;
      in_pkt_d = in_pkt_q;
      drop_inc = 2'd0;
      if (accept) in_pkt_d = !bus.s_last;
      case (state_q)
         WG_BLOCK: begin
            if (bus.en_wr_en) state_d = WG_RUN;
         end
         WG_RUN: begin
            // Ready was only granted with at most one beat buffered, so this never exceeds 2.
            if (!bus.en_wr_en) begin
               drop_inc = occ + {1'b0, accept};
               state_d  = in_pkt_d ? WG_DROP : WG_BLOCK;
            end
         end
         WG_DROP: begin
            if (accept) begin
               drop_inc = 2'd1;
               if (bus.s_last) state_d = bus.en_wr_en ? WG_RUN : WG_BLOCK;
            end
         end
         default: state_d = WG_BLOCK;
      endcase
      s_ready_d = (state_d != WG_BLOCK) && ((state_d == WG_DROP) || (occ_next <= 2'd1));
   end

   assign pkt_cnt_d  = CNT_W'(sat_add(32'(pkt_cnt_q), {1'b0, wr_fire && buf_out_data[DSIZE]}, CNT_W));
   assign drop_cnt_d = CNT_W'(sat_add(32'(drop_cnt_q), drop_inc, CNT_W));

   always_ff @(posedge wr_clk or posedge wr_rst_Q) begin
      if (wr_rst_Q) begin
         state_q    <= WG_BLOCK;
         s_ready_q  <= 1'b0;
         in_pkt_q   <= 1'b0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         s_ready_q  <= s_ready_d;
         in_pkt_q   <= in_pkt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.s_ready    = s_ready_q;
   assign bus.fifo_wr_en = wr_fire;
   assign bus.fifo_din   = buf_out_data;
   assign bus.pkt_cnt    = pkt_cnt_q;
   assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_guard.sv
// Scoreboard bench for fifo_wr_guard: directed packets push expected FIFO words, a monitor checks writes.
module tb_fifo_wr_guard;

   localparam int DSIZE = 16;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   acc_n  = 0;
   int   wr_n   = 0;
   int   base_acc;
   logic [DSIZE:0] exp_q [$];
   logic [DSIZE:0] exp_word;

   fifo_wr_guard_if #(.DSIZE(DSIZE), .CNT_W(CNT_W)) bus ();

   fifo_wr_guard #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
      .wr_clk   (clk),
      .wr_rst_Q (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until the registered ready lets it through.
   task automatic send(input logic [DSIZE-1:0] d, input logic l, input bit exp_wr);
      int n;
      n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      while (!bus.s_ready && n < 100) begin
         tick();
         n++;
      end
      if (!bus.s_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: beat %h got no ready in 100 cycles, required ready=1", d);
      end else begin
         acc_n++;
         if (exp_wr) exp_q.push_back({l, d});
      end
      tick();
   endtask

   task automatic send_pkt(input logic [DSIZE-1:0] base, input int len, input bit exp_wr);
      for (int i = 0; i < len; i++) send(base + DSIZE'(i), (i == len - 1), exp_wr);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bus.fifo_wr_en === 1'b1) begin
         checks++;
         wr_n++;
         if (bus.fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL write_while_full: fifo_wr_en=1 with fifo_full=%b, required no write", bus.fifo_full);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: din=%h written, required no write", bus.fifo_din);
         end else begin
            exp_word = exp_q.pop_front();
            if (bus.fifo_din !== exp_word) begin
               errors++;
               $display("FAIL write_data: din=%h, expected %h", bus.fifo_din, exp_word);
            end else begin
               $display("write %0d: din=%h", wr_n, bus.fifo_din);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en_wr_en  = 1'b0;
      bus.s_data    = '0;
      bus.s_valid   = 1'b0;
      bus.s_last    = 1'b0;
      bus.fifo_full = 1'b0;

      // 1. reset state and release
      repeat (3) tick();
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_wr_en", bus.fifo_wr_en, 0);
      chk("rst_din", bus.fifo_din, 0);
      chk("rst_pkt_cnt", bus.pkt_cnt, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      rst = 1'b0;
      repeat (6) tick();
      chk("blocked_ready", bus.s_ready, 0);
      bus.en_wr_en = 1'b1;
      chk("ready_same_cycle", bus.s_ready, 0);
      tick();
      chk("ready_after_en", bus.s_ready, 1);
      send_pkt(16'hA000, 4, 1'b1);
      repeat (5) tick();
      chk("t1_pkt_cnt", bus.pkt_cnt, 1);
      chk("t1_drop_cnt", bus.drop_cnt, 0);
      chk("t1_pending", exp_q.size(), 0);

      // 2. backpressure for 20 cycles during a 10-beat packet
      bus.fifo_full = 1'b1;
      base_acc = acc_n;
      fork
         send_pkt(16'hB000, 10, 1'b1);
         begin
            repeat (10) tick();
            chk("t2_buffered", acc_n - base_acc, 2);
            chk("t2_ready_full", bus.s_ready, 0);
            chk("t2_wr_full", bus.fifo_wr_en, 0);
            repeat (10) tick();
            bus.fifo_full = 1'b0;
         end
      join
      repeat (5) tick();
      chk("t2_accepted", acc_n - base_acc, 10);
      chk("t2_pkt_cnt", bus.pkt_cnt, 2);
      chk("t2_drop_cnt", bus.drop_cnt, 0);
      chk("t2_pending", exp_q.size(), 0);

      // 3. cut packet: C1 written, C2/C3 buffered, enable falls
      send(16'hC001, 1'b0, 1'b1);
      send(16'hC002, 1'b0, 1'b0);
      bus.fifo_full = 1'b1;
      send(16'hC003, 1'b0, 1'b0);
      bus.s_valid  = 1'b0;
      bus.en_wr_en = 1'b0;
      tick();
      chk("t3_flush_drop", bus.drop_cnt, 2);
      chk("t3_drop_ready", bus.s_ready, 1);
      bus.fifo_full = 1'b0;
      for (int i = 4; i <= 8; i++) send(16'hC000 + DSIZE'(i), (i == 8), 1'b0);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      chk("t3_drop_cnt", bus.drop_cnt, 7);
      chk("t3_block_ready", bus.s_ready, 0);
      chk("t3_pkt_cnt_kept", bus.pkt_cnt, 2);
      bus.en_wr_en = 1'b1;
      tick();
      chk("t3_reenable", bus.s_ready, 1);
      send_pkt(16'hD000, 3, 1'b1);
      repeat (5) tick();
      chk("t3_pkt_cnt", bus.pkt_cnt, 3);
      chk("t3_pending", exp_q.size(), 0);

      // 4. clean stop between packets
      bus.en_wr_en = 1'b0;
      tick();
      chk("t4_ready", bus.s_ready, 0);
      chk("t4_drop_cnt", bus.drop_cnt, 7);
      repeat (3) tick();
      chk("t4_ready_held", bus.s_ready, 0);
      bus.en_wr_en = 1'b1;
      tick();
      send_pkt(16'hE000, 2, 1'b1);
      repeat (5) tick();
      chk("t4_pkt_cnt", bus.pkt_cnt, 4);
      chk("t4_pending", exp_q.size(), 0);

      // 5. asynchronous reset while a write is in progress
      send(16'hF000, 1'b0, 1'b1);
      send(16'hF001, 1'b0, 1'b1);
      bus.s_valid = 1'b0;
      chk("t5_wr_before", bus.fifo_wr_en, 1);
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("t5_wr_en", bus.fifo_wr_en, 0);
      chk("t5_ready", bus.s_ready, 0);
      chk("t5_din", bus.fifo_din, 0);
      chk("t5_pkt_cnt", bus.pkt_cnt, 0);
      chk("t5_drop_cnt", bus.drop_cnt, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("t5_run_ready", bus.s_ready, 1);
      bus.en_wr_en = 1'b0;
      tick();
      chk("t5_in_pkt_clear", bus.s_ready, 0);
      chk("t5_drop_after", bus.drop_cnt, 0);

      // 6. drop counter saturation (CNT_W=4)
      bus.en_wr_en = 1'b1;
      tick();
      send(16'h5000, 1'b0, 1'b1);
      bus.s_valid = 1'b0;
      repeat (3) tick();
      bus.en_wr_en = 1'b0;
      tick();
      chk("t6_drop_state", bus.s_ready, 1);
      for (int i = 0; i < 20; i++) begin
         send(16'h6000 + DSIZE'(i), (i == 19), 1'b0);
         if (i == 14) chk("t6_drop_15", bus.drop_cnt, 15);
         if (i == 15) chk("t6_drop_sat", bus.drop_cnt, 15);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      chk("t6_drop_final", bus.drop_cnt, 15);
      chk("t6_block", bus.s_ready, 0);
      chk("t6_pkt_cnt", bus.pkt_cnt, 0);
      chk("t6_pending", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
